// File: rtl/t_ff_toggle_arbiter_if.sv
// Requester-side handshake bundle for the shared T flip-flop arbiter.
// The arbiter takes the slave view; requester logic takes the master view.
interface t_ff_toggle_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int CNT_W = 4
);
   logic [NREQ-1:0]       req;
   logic [NREQ*CNT_W-1:0] cnt_in;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       done;

   modport master (
      output req,
      output cnt_in,
      input  gnt,
      input  done
   );

   modport slave (
      input  req,
      input  cnt_in,
      output gnt,
      output done
   );
endinterface

// File: rtl/t_ff_toggle_arbiter.sv
// Round-robin arbiter that lends one external T flip-flop to NREQ requesters,
// pulses t for the granted count and tracks q with a shadow model.
module t_ff_toggle_arbiter #(
   parameter int NREQ  = 4,
   parameter int CNT_W = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   t_ff_toggle_arbiter_if.slave  bus,
   output logic                  t,
   input  logic                  q_in,
   output logic                  q_exp,
   output logic                  err,
   output logic                  busy
);
   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, TOGGLE, DONE} state_t;

   state_t             state_reg;
   logic [PTR_W-1:0]   ptr_reg;
   logic [PTR_W-1:0]   sel_reg;
   logic [PTR_W-1:0]   sel_next;
   logic [CNT_W-1:0]   remaining_reg;
   logic [NREQ-1:0]    gnt_reg;
   logic [NREQ-1:0]    done_reg;
   logic               t_reg;
   logic               q_exp_reg;
   logic               err_reg;
   logic               busy_reg;

   logic [CNT_W-1:0]   cnt_arr  [NREQ];
   logic [PTR_W-1:0]   cand_idx [NREQ];
   logic [NREQ-1:0]    cand_hit;

   // Candidate gi is the requester gi places above the pointer, wrapped modulo NREQ.
   for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
      logic [PTR_W:0] sum;
      assign sum          = {1'b0, ptr_reg} + (PTR_W+1)'(gi);
      assign cand_idx[gi] = (sum >= (PTR_W+1)'(NREQ)) ? PTR_W'(sum - (PTR_W+1)'(NREQ))
                                                      : PTR_W'(sum);
      assign cand_hit[gi] = bus.req[cand_idx[gi]];
      assign cnt_arr[gi]  = bus.cnt_in[gi*CNT_W +: CNT_W];
   end

   always_comb begin
      sel_next = ptr_reg;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (cand_hit[k]) sel_next = cand_idx[k];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         ptr_reg       <= '0;
         sel_reg       <= '0;
         remaining_reg <= '0;
         gnt_reg       <= '0;
         done_reg      <= '0;
         t_reg         <= 1'b0;
         q_exp_reg     <= 1'b0;
         err_reg       <= 1'b0;
         busy_reg      <= 1'b0;
      end else begin
         q_exp_reg <= q_exp_reg ^ t_reg;
         if (q_in != q_exp_reg) err_reg <= 1'b1;

         case (state_reg)
            IDLE: begin
               if (|bus.req) begin
                  sel_reg       <= sel_next;
                  gnt_reg       <= {{(NREQ-1){1'b0}}, 1'b1} << sel_next;
                  remaining_reg <= cnt_arr[sel_next];
                  busy_reg      <= 1'b1;
                  if (cnt_arr[sel_next] == '0) begin
                     t_reg     <= 1'b0;
                     state_reg <= DONE;
                  end else begin
                     t_reg     <= 1'b1;
                     state_reg <= TOGGLE;
                  end
               end
            end
            TOGGLE: begin
               remaining_reg <= remaining_reg - CNT_W'(1);
               if (remaining_reg == CNT_W'(1)) begin
                  t_reg     <= 1'b0;
                  state_reg <= DONE;
               end
            end
            DONE: begin
               // First edge in DONE raises the pulse, the next one retires the grant.
               if (done_reg == '0) begin
                  done_reg <= gnt_reg;
               end else begin
                  done_reg  <= '0;
                  gnt_reg   <= '0;
                  busy_reg  <= 1'b0;
                  ptr_reg   <= (sel_reg == PTR_W'(NREQ - 1)) ? '0 : sel_reg + PTR_W'(1);
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.gnt  = gnt_reg;
   assign bus.done = done_reg;
   assign t        = t_reg;
   assign q_exp    = q_exp_reg;
   assign err      = err_reg;
   assign busy     = busy_reg;
endmodule
